// File: rtl/cdb_arbiter.sv
// Common data bus writeback arbiter: round-robin selection among FU results into a
// single registered broadcast slot, with flush and single-uop recovery kill.
module cdb_arbiter #(
    parameter int FU_NUM  = 4,
    parameter int PHYS_W  = 6,
    parameter int ROB_W   = 5,
    parameter int EPOCH_W = 2,
    parameter int XLEN    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FU_NUM-1:0]         fu_valid,
    output logic [FU_NUM-1:0]         fu_ready,
    input  logic [FU_NUM*PHYS_W-1:0]  fu_pd,
    input  logic [FU_NUM*ROB_W-1:0]   fu_rob_idx,
    input  logic [FU_NUM*EPOCH_W-1:0] fu_epoch,
    input  logic [FU_NUM*XLEN-1:0]    fu_data,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [PHYS_W-1:0]         wb_pd,
    output logic [ROB_W-1:0]          wb_rob_idx,
    output logic [EPOCH_W-1:0]        wb_epoch,
    output logic [XLEN-1:0]           wb_data,
    input  logic                      flush_valid,
    input  logic                      recover_valid,
    input  logic [ROB_W-1:0]          recover_rob_idx,
    input  logic [EPOCH_W-1:0]        recover_epoch,
    output logic                      busy
);

    localparam int IDX_W = $clog2(FU_NUM);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               wb_valid_q, wb_valid_d;
    logic [PHYS_W-1:0]  wb_pd_q, wb_pd_d;
    logic [ROB_W-1:0]   wb_rob_idx_q, wb_rob_idx_d;
    logic [EPOCH_W-1:0] wb_epoch_q, wb_epoch_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;

    logic [FU_NUM-1:0]  req_kill;
    logic               out_kill;
    logic               slot_free;
    logic               grant;
    logic               grant_kill;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     cand_sum;
    logic [IDX_W-1:0]   cand;
    logic [PHYS_W-1:0]  sel_pd;
    logic [ROB_W-1:0]   sel_rob_idx;
    logic [EPOCH_W-1:0] sel_epoch;
    logic [XLEN-1:0]    sel_data;

    always_comb begin
        req_kill = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            req_kill[i] = recover_valid
                       && (fu_rob_idx[i*ROB_W +: ROB_W] == recover_rob_idx)
                       && (fu_epoch[i*EPOCH_W +: EPOCH_W] == recover_epoch);
        end
    end

    assign out_kill = wb_valid_q && recover_valid
                   && (wb_rob_idx_q == recover_rob_idx) && (wb_epoch_q == recover_epoch);

    // A killed output entry vacates the slot, so a grant can refill it on the same edge.
    assign slot_free = !wb_valid_q || wb_ready || out_kill;

    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        if (slot_free && !flush_valid && !rst) begin
            for (int k = 0; k < FU_NUM; k++) begin
                cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
                if (cand_sum >= (IDX_W+1)'(FU_NUM)) begin
                    cand_sum = cand_sum - (IDX_W+1)'(FU_NUM);
                end
                cand = cand_sum[IDX_W-1:0];
                if (!grant && fu_valid[cand]) begin
                    grant     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        fu_ready    = '0;
        grant_kill  = 1'b0;
        sel_pd      = '0;
        sel_rob_idx = '0;
        sel_epoch   = '0;
        sel_data    = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                fu_ready[i] = grant;
                grant_kill  = req_kill[i];
                sel_pd      = fu_pd[i*PHYS_W +: PHYS_W];
                sel_rob_idx = fu_rob_idx[i*ROB_W +: ROB_W];
                sel_epoch   = fu_epoch[i*EPOCH_W +: EPOCH_W];
                sel_data    = fu_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        wb_valid_d   = wb_valid_q;
        wb_pd_d      = wb_pd_q;
        wb_rob_idx_d = wb_rob_idx_q;
        wb_epoch_d   = wb_epoch_q;
        wb_data_d    = wb_data_q;
        if (flush_valid) begin
            wb_valid_d = 1'b0;
            rr_ptr_d   = '0;
        end else begin
            if (wb_valid_q && (wb_ready || out_kill)) begin
                wb_valid_d = 1'b0;
            end
            if (grant) begin
                rr_ptr_d = (grant_idx == IDX_W'(FU_NUM-1)) ? '0 : grant_idx + 1'b1;
                // A recovered requester is consumed but never reaches the bus.
                if (!grant_kill) begin
                    wb_valid_d   = 1'b1;
                    wb_pd_d      = sel_pd;
                    wb_rob_idx_d = sel_rob_idx;
                    wb_epoch_d   = sel_epoch;
                    wb_data_d    = sel_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_pd_q      <= '0;
            wb_rob_idx_q <= '0;
            wb_epoch_q   <= '0;
            wb_data_q    <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wb_valid_q   <= wb_valid_d;
            wb_pd_q      <= wb_pd_d;
            wb_rob_idx_q <= wb_rob_idx_d;
            wb_epoch_q   <= wb_epoch_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_pd      = wb_pd_q;
    assign wb_rob_idx = wb_rob_idx_q;
    assign wb_epoch   = wb_epoch_q;
    assign wb_data    = wb_data_q;
    assign busy       = wb_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenario tasks plus a randomized phase, with broadcast
// payloads checked against an expected queue by a negedge monitor.
module tb_cdb_arbiter;

    localparam int FU_NUM  = 4;
    localparam int PHYS_W  = 6;
    localparam int ROB_W   = 5;
    localparam int EPOCH_W = 2;
    localparam int XLEN    = 32;
    localparam int PAY_W   = PHYS_W + ROB_W + EPOCH_W + XLEN;

    logic                      clk;
    logic                      rst;
    logic [FU_NUM-1:0]         fu_valid;
    logic [FU_NUM-1:0]         fu_ready;
    logic [FU_NUM*PHYS_W-1:0]  fu_pd;
    logic [FU_NUM*ROB_W-1:0]   fu_rob_idx;
    logic [FU_NUM*EPOCH_W-1:0] fu_epoch;
    logic [FU_NUM*XLEN-1:0]    fu_data;
    logic                      wb_valid;
    logic                      wb_ready;
    logic [PHYS_W-1:0]         wb_pd;
    logic [ROB_W-1:0]          wb_rob_idx;
    logic [EPOCH_W-1:0]        wb_epoch;
    logic [XLEN-1:0]           wb_data;
    logic                      flush_valid;
    logic                      recover_valid;
    logic [ROB_W-1:0]          recover_rob_idx;
    logic [EPOCH_W-1:0]        recover_epoch;
    logic                      busy;

    int errors = 0;
    int checks = 0;
    int bcasts = 0;
    logic [PAY_W-1:0] exp_q[$];
    logic [PAY_W-1:0] mon_exp;
    logic [PAY_W-1:0] wb_pay;

    assign wb_pay = {wb_pd, wb_rob_idx, wb_epoch, wb_data};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter #(
        .FU_NUM(FU_NUM), .PHYS_W(PHYS_W), .ROB_W(ROB_W), .EPOCH_W(EPOCH_W), .XLEN(XLEN)
    ) dut (
        .clk(clk), .rst(rst),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_pd(fu_pd), .fu_rob_idx(fu_rob_idx), .fu_epoch(fu_epoch), .fu_data(fu_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_pd(wb_pd), .wb_rob_idx(wb_rob_idx), .wb_epoch(wb_epoch), .wb_data(wb_data),
        .flush_valid(flush_valid), .recover_valid(recover_valid),
        .recover_rob_idx(recover_rob_idx), .recover_epoch(recover_epoch),
        .busy(busy)
    );

    // scoreboard: every accepted broadcast must match the oldest expected payload
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            bcasts++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL broadcast: got payload %h, expected none queued", wb_pay);
            end else begin
                mon_exp = exp_q.pop_front();
                if (wb_pay !== mon_exp) begin
                    errors++;
                    $display("FAIL broadcast: got payload %h, expected %h", wb_pay, mon_exp);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [PHYS_W-1:0] pd, input logic [ROB_W-1:0] rob,
                          input logic [EPOCH_W-1:0] ep, input logic [XLEN-1:0] data);
        fu_pd[i*PHYS_W +: PHYS_W]       = pd;
        fu_rob_idx[i*ROB_W +: ROB_W]    = rob;
        fu_epoch[i*EPOCH_W +: EPOCH_W]  = ep;
        fu_data[i*XLEN +: XLEN]         = data;
    endtask

    task automatic rand_fu(input int i);
        set_fu(i, PHYS_W'($urandom), ROB_W'($urandom_range(0, 3)),
               EPOCH_W'($urandom_range(0, 1)), $urandom);
    endtask

    function automatic logic [PAY_W-1:0] fu_pay(input int i);
        return {fu_pd[i*PHYS_W +: PHYS_W], fu_rob_idx[i*ROB_W +: ROB_W],
                fu_epoch[i*EPOCH_W +: EPOCH_W], fu_data[i*XLEN +: XLEN]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        fu_valid = 4'b1111;
        wb_ready = 1'b1;
        #12;
        checks++; if (fu_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", fu_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        fu_valid = 4'b0000;
        #1;
        checks++; if (fu_ready !== 4'b0000) begin errors++; $display("FAIL post_reset_ready: got %b expected 0000", fu_ready); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", wb_valid); end
    endtask

    task automatic test_round_robin();
        logic [FU_NUM-1:0] e;
        wb_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < FU_NUM; i++) rand_fu(i);
            fu_valid = 4'b1111;
            #1;
            e = '0;
            e[k % FU_NUM] = 1'b1;
            checks++; if (fu_ready !== e) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, fu_ready, e); end
            exp_q.push_back(fu_pay(k % FU_NUM));
            tick();
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL rr_valid%0d: got %b expected 1", k, wb_valid); end
        end
        fu_valid = 4'b0000;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", wb_valid); end
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        set_fu(2, 6'h15, 5'd3, 2'd0, 32'hcafe_0015);
        fu_valid = 4'b0100;
        #1;
        checks++; if (fu_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b expected 0100", fu_ready); end
        exp_q.push_back(fu_pay(2));
        tick();
        for (int c = 0; c < 3; c++) begin
            set_fu(2, 6'h2a, 5'd4, 2'd1, 32'hbeef_002a);
            #1;
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b expected 1", c, wb_valid); end
            checks++; if (wb_pd !== 6'h15) begin errors++; $display("FAIL bp_pd%0d: got %h expected 15", c, wb_pd); end
            checks++; if (fu_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold_ready%0d: got %b expected 0000", c, fu_ready); end
            tick();
        end
        wb_ready = 1'b1;
        #1;
        checks++; if (fu_ready !== 4'b0100) begin errors++; $display("FAIL bp_release: got %b expected 0100", fu_ready); end
        exp_q.push_back(fu_pay(2));
        tick();
        fu_valid = 4'b0000;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", wb_valid); end
    endtask

    task automatic test_rr_wrap();
        wb_ready = 1'b1;
        rand_fu(1);
        fu_valid = 4'b0010;
        #1;
        checks++; if (fu_ready !== 4'b0010) begin errors++; $display("FAIL wrap_fu1: got %b expected 0010", fu_ready); end
        exp_q.push_back(fu_pay(1));
        tick();
        for (int i = 0; i < FU_NUM; i++) rand_fu(i);
        fu_valid = 4'b1011;
        #1;
        checks++; if (fu_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ptr2: got %b expected 1000", fu_ready); end
        exp_q.push_back(fu_pay(3));
        tick();
        fu_valid = 4'b0000;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %b expected 0", wb_valid); end
    endtask

    task automatic test_recover();
        wb_ready = 1'b0;
        set_fu(1, 6'h07, 5'd7, 2'd1, 32'h0000_0007);
        fu_valid = 4'b0010;
        #1;
        checks++; if (fu_ready !== 4'b0010) begin errors++; $display("FAIL rec_load: got %b expected 0010", fu_ready); end
        exp_q.push_back(fu_pay(1));
        tick();
        set_fu(0, 6'h09, 5'd9, 2'd1, 32'h0000_0009);
        fu_valid = 4'b0001;
        recover_valid = 1'b1;
        recover_rob_idx = 5'd7;
        recover_epoch = 2'd1;
        #1;
        checks++; if (fu_ready !== 4'b0001) begin errors++; $display("FAIL rec_refill: got %b expected 0001", fu_ready); end
        void'(exp_q.pop_front());
        exp_q.push_back(fu_pay(0));
        tick();
        recover_valid = 1'b0;
        fu_valid = 4'b0000;
        #1;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL rec_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_rob_idx !== 5'd9) begin errors++; $display("FAIL rec_rob: got %0d expected 9", wb_rob_idx); end
        wb_ready = 1'b1;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rec_drain: got %b expected 0", wb_valid); end
        set_fu(1, 6'h11, 5'd5, 2'd3, 32'h1111_1111);
        set_fu(2, 6'h12, 5'd6, 2'd2, 32'h2222_2222);
        fu_valid = 4'b0110;
        recover_valid = 1'b1;
        recover_rob_idx = 5'd5;
        recover_epoch = 2'd3;
        #1;
        checks++; if (fu_ready !== 4'b0010) begin errors++; $display("FAIL drop_ready: got %b expected 0010", fu_ready); end
        tick();
        recover_valid = 1'b0;
        set_fu(1, 6'h13, 5'd8, 2'd0, 32'h3333_3333);
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL drop_no_bcast: got %b expected 0", wb_valid); end
        checks++; if (fu_ready !== 4'b0100) begin errors++; $display("FAIL drop_ptr: got %b expected 0100", fu_ready); end
        exp_q.push_back(fu_pay(2));
        tick();
        fu_valid = 4'b0000;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL drop_drain: got %b expected 0", wb_valid); end
    endtask

    task automatic test_flush();
        wb_ready = 1'b0;
        set_fu(2, 6'h22, 5'd10, 2'd2, 32'h4444_4444);
        fu_valid = 4'b0100;
        #1;
        checks++; if (fu_ready !== 4'b0100) begin errors++; $display("FAIL fl_load: got %b expected 0100", fu_ready); end
        exp_q.push_back(fu_pay(2));
        tick();
        for (int i = 0; i < FU_NUM; i++) rand_fu(i);
        fu_valid = 4'b1111;
        flush_valid = 1'b1;
        #1;
        checks++; if (fu_ready !== 4'b0000) begin errors++; $display("FAIL fl_ready: got %b expected 0000", fu_ready); end
        exp_q.delete();
        tick();
        flush_valid = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fl_cleared: got %b expected 0", wb_valid); end
        wb_ready = 1'b1;
        #1;
        checks++; if (fu_ready !== 4'b0001) begin errors++; $display("FAIL fl_ptr_reset: got %b expected 0001", fu_ready); end
        exp_q.push_back(fu_pay(0));
        tick();
        fu_valid = 4'b0000;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fl_drain: got %b expected 0", wb_valid); end
    endtask

    task automatic test_async_reset();
        int b0;
        wb_ready = 1'b0;
        rand_fu(0);
        fu_valid = 4'b0001;
        #1;
        checks++; if (fu_ready !== 4'b0001) begin errors++; $display("FAIL ar_load: got %b expected 0001", fu_ready); end
        exp_q.push_back(fu_pay(0));
        tick();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL ar_held: got %b expected 1", wb_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ar_async: got %b expected 0", wb_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b expected 0", busy); end
        checks++; if (fu_ready !== 4'b0000) begin errors++; $display("FAIL ar_ready: got %b expected 0000", fu_ready); end
        exp_q.delete();
        b0 = bcasts;
        fu_valid = 4'b0000;
        wb_ready = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ar_release%0d: got %b expected 0", c, wb_valid); end
        end
        checks++; if (bcasts !== b0) begin errors++; $display("FAIL ar_no_bcast: got %0d broadcasts expected %0d", bcasts, b0); end
        for (int i = 0; i < FU_NUM; i++) rand_fu(i);
        fu_valid = 4'b1111;
        #1;
        checks++; if (fu_ready !== 4'b0001) begin errors++; $display("FAIL ar_ptr: got %b expected 0001", fu_ready); end
        exp_q.push_back(fu_pay(0));
        tick();
        fu_valid = 4'b0000;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ar_drain: got %b expected 0", wb_valid); end
    endtask

    task automatic test_random();
        int m_rr;
        int g;
        int idx;
        logic m_busy;
        logic okill;
        logic [PAY_W-1:0] head;
        logic [FU_NUM-1:0] e;
        flush_valid = 1'b1;
        wb_ready = 1'b0;
        tick();
        flush_valid = 1'b0;
        exp_q.delete();
        m_rr = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < FU_NUM; i++) rand_fu(i);
            fu_valid = FU_NUM'($urandom);
            wb_ready = ($urandom_range(0, 3) != 0);
            flush_valid = ($urandom_range(0, 19) == 0);
            if (flush_valid) wb_ready = 1'b0;
            recover_valid = ($urandom_range(0, 3) == 0);
            recover_rob_idx = ROB_W'($urandom_range(0, 3));
            recover_epoch = EPOCH_W'($urandom_range(0, 1));
            #1;
            m_busy = (exp_q.size() != 0);
            checks++; if (wb_valid !== m_busy) begin errors++; $display("FAIL rnd_valid%0d: got %b expected %b", cyc, wb_valid, m_busy); end
            okill = 1'b0;
            if (m_busy) begin
                head = exp_q[0];
                okill = recover_valid && (head[XLEN+EPOCH_W +: ROB_W] == recover_rob_idx)
                        && (head[XLEN +: EPOCH_W] == recover_epoch);
            end
            g = -1;
            if (!flush_valid && (!m_busy || wb_ready || okill)) begin
                for (int k = 0; k < FU_NUM; k++) begin
                    idx = (m_rr + k) % FU_NUM;
                    if (g < 0 && fu_valid[idx]) g = idx;
                end
            end
            e = '0;
            if (g >= 0) e[g] = 1'b1;
            checks++; if (fu_ready !== e) begin errors++; $display("FAIL rnd_ready%0d: got %b expected %b", cyc, fu_ready, e); end
            if (flush_valid) begin
                exp_q.delete();
                m_rr = 0;
            end else begin
                if (okill && !wb_ready) void'(exp_q.pop_front());
                if (g >= 0) begin
                    m_rr = (g + 1) % FU_NUM;
                    if (!(recover_valid && fu_rob_idx[g*ROB_W +: ROB_W] == recover_rob_idx
                          && fu_epoch[g*EPOCH_W +: EPOCH_W] == recover_epoch))
                        exp_q.push_back(fu_pay(g));
                end
            end
            tick();
        end
        fu_valid = 4'b0000;
        flush_valid = 1'b0;
        recover_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got %b expected 0", wb_valid); end
    endtask

    initial begin
        rst = 1'b1;
        fu_valid = '0;
        fu_pd = '0;
        fu_rob_idx = '0;
        fu_epoch = '0;
        fu_data = '0;
        wb_ready = 1'b0;
        flush_valid = 1'b0;
        recover_valid = 1'b0;
        recover_rob_idx = '0;
        recover_epoch = '0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_rr_wrap();
        test_recover();
        test_flush();
        test_async_reset();
        test_random();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: got %0d queued results expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
